// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage definitions: instruction width, NOP encoding, PC step,
// R-type field positions (shared with the control unit) and the built-in
// boot program image used to populate the instruction ROM.
package instruction_fetch_pkg;

    localparam int INSTR_W = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP = 32'd4;

    // Field positions: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], funct [5:0]
    localparam int OPCODE_LSB = 26;
    localparam int OPCODE_W = 6;
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;
    localparam int RD_LSB = 11;
    localparam int REG_W = 5;
    localparam int FUNCT_LSB = 0;
    localparam int FUNCT_W = 6;

    // Per-edge action chosen by the fetch priority decoder.
    typedef enum logic [2:0] {
        FETCH_RESET,
        FETCH_REDIRECT,
        FETCH_HOLD,
        FETCH_SQUASH,
        FETCH_NORMAL
    } fetch_op_e;

    // Pack an R-type instruction word; shamt is left at zero.
    function automatic logic [INSTR_W-1:0] rtype_word(
        input logic [OPCODE_W-1:0] op,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic [REG_W-1:0] rd,
        input logic [FUNCT_W-1:0] funct
    );
        logic [INSTR_W-1:0] w;
        w = '0;
        w[OPCODE_LSB +: OPCODE_W] = op;
        w[RS_LSB +: REG_W] = rs;
        w[RT_LSB +: REG_W] = rt;
        w[RD_LSB +: REG_W] = rd;
        w[FUNCT_LSB +: FUNCT_W] = funct;
        return w;
    endfunction

    // Boot program image (contents of instrucciones.mem); unlisted words are NOPs.
    function automatic logic [INSTR_W-1:0] boot_image_word(input int unsigned idx);
        case (idx)
            0: return rtype_word(6'd0, 5'd1, 5'd2, 5'd3, 6'h20);
            1: return rtype_word(6'd0, 5'd2, 5'd3, 5'd4, 6'h22);
            2: return rtype_word(6'd0, 5'd4, 5'd5, 5'd6, 6'h24);
            3: return rtype_word(6'd0, 5'd6, 5'd6, 5'd7, 6'h25);
            4: return rtype_word(6'd0, 5'd7, 5'd7, 5'd8, 6'h20);
            5: return rtype_word(6'd0, 5'd8, 5'd1, 5'd9, 6'h22);
            6: return rtype_word(6'd0, 5'd9, 5'd2, 5'd10, 6'h24);
            7: return rtype_word(6'd0, 5'd10, 5'd3, 5'd11, 6'h25);
            default: return NOP_INSTR;
        endcase
    endfunction

endpackage

// File: rtl/instruction_rom.sv
// Word-organised instruction ROM with a combinational byte-address read port.
// Addresses at or beyond MEM_DEPTH*4 return a NOP and raise out_of_range,
// so high addresses never alias onto low words.
module instruction_rom
    import instruction_fetch_pkg::*;
#(
    parameter int MEM_DEPTH = 64,
    parameter string INIT_FILE = "instrucciones.mem"
) (
    input  logic [31:0]        addr,
    output logic [INSTR_W-1:0] data,
    output logic               out_of_range
);

    localparam int AW = $clog2(MEM_DEPTH);
    // An empty image name elaborates a blank (all-NOP) ROM.
    localparam bit BLANK_IMAGE = (INIT_FILE == "");
    localparam logic [31:0] BYTE_LIMIT = 32'(MEM_DEPTH) << 2;

    logic [INSTR_W-1:0] w_mem [MEM_DEPTH];
    logic [AW-1:0]      w_index;

    generate
        for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : g_word
            assign w_mem[gi] = BLANK_IMAGE ? NOP_INSTR : boot_image_word(gi);
        end
    endgenerate

    // Decode the word index and substitute a NOP for out-of-range fetches.
    always_comb begin
        w_index = addr[AW+1:2];
        out_of_range = (addr >= BYTE_LIMIT);
        data = out_of_range ? NOP_INSTR : w_mem[w_index];
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: program counter, ROM lookup and the fetch/decode pipeline
// register feeding TR. Per-edge priority is rst > br_taken > stall > flush > normal.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int MEM_DEPTH = 64,
    parameter string INIT_FILE = "instrucciones.mem",
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               br_taken,
    input  logic [31:0]        br_target,
    output logic [INSTR_W-1:0] TR,
    output logic               tr_valid,
    output logic [31:0]        pc_out,
    output logic [31:0]        pc_plus4,
    output logic               fetch_err,
    output logic [31:0]        inst_count
);

    logic [31:0]        r_pc;
    logic [INSTR_W-1:0] r_tr;
    logic               r_tr_valid;
    logic [31:0]        r_pc_out;
    logic [31:0]        r_pc_plus4;
    logic               r_fetch_err;
    logic [31:0]        r_inst_count;

    logic [INSTR_W-1:0] w_rom_data;
    logic               w_rom_oor;
    fetch_op_e          w_op;

    instruction_rom #(
        .MEM_DEPTH(MEM_DEPTH),
        .INIT_FILE(INIT_FILE)
    ) u_rom (
        .addr        (r_pc),
        .data        (w_rom_data),
        .out_of_range(w_rom_oor)
    );

    // Resolve the competing controls into a single action for this edge.
    always_comb begin
        w_op = FETCH_NORMAL;
        if (rst) begin
            w_op = FETCH_RESET;
        end else if (br_taken) begin
            w_op = FETCH_REDIRECT;
        end else if (stall) begin
            w_op = FETCH_HOLD;
        end else if (flush) begin
            w_op = FETCH_SQUASH;
        end
    end

    // PC, pipeline register, sticky error flag and delivered-instruction counter.
    always_ff @(posedge clk) begin
        case (w_op)
            FETCH_RESET: begin
                r_pc         <= RESET_PC;
                r_tr         <= NOP_INSTR;
                r_tr_valid   <= 1'b0;
                r_pc_out     <= 32'h0;
                r_pc_plus4   <= PC_STEP;
                r_fetch_err  <= 1'b0;
                r_inst_count <= 32'h0;
            end
            FETCH_REDIRECT: begin
                // Targets are forced to word alignment; pc_out/pc_plus4 keep the last real fetch.
                r_pc       <= br_target & ~32'h3;
                r_tr       <= NOP_INSTR;
                r_tr_valid <= 1'b0;
            end
            FETCH_SQUASH: begin
                // The word at the current PC is dropped, not replayed.
                r_pc       <= r_pc + PC_STEP;
                r_tr       <= NOP_INSTR;
                r_tr_valid <= 1'b0;
            end
            FETCH_NORMAL: begin
                r_pc         <= r_pc + PC_STEP;
                r_tr         <= w_rom_data;
                r_tr_valid   <= 1'b1;
                r_pc_out     <= r_pc;
                r_pc_plus4   <= r_pc + PC_STEP;
                r_inst_count <= r_inst_count + 32'd1;
                if (w_rom_oor) begin
                    r_fetch_err <= 1'b1;
                end
            end
            default: begin
                // FETCH_HOLD: everything keeps its value.
            end
        endcase
    end

    assign TR         = r_tr;
    assign tr_valid   = r_tr_valid;
    assign pc_out     = r_pc_out;
    assign pc_plus4   = r_pc_plus4;
    assign fetch_err  = r_fetch_err;
    assign inst_count = r_inst_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a 64-word instance driven through
// sequential fetch, stall, flush, redirect, reset and PC wrap, plus a 4-word
// instance sharing the same stimulus for the out-of-range error path.
module tb_instruction_fetch;

    localparam logic [31:0] R0 = 32'h00221820;
    localparam logic [31:0] R1 = 32'h00432022;
    localparam logic [31:0] R2 = 32'h00853024;
    localparam logic [31:0] R3 = 32'h00C63825;
    localparam logic [31:0] R4 = 32'h00E74020;
    localparam logic [31:0] R5 = 32'h01014822;
    localparam logic [31:0] R6 = 32'h01225024;

    typedef struct {
        logic [31:0] tr;
        logic        v;
        logic [31:0] pc;
        logic [31:0] cnt;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        br_taken;
    logic [31:0] br_target;

    logic [31:0] a_tr, a_pc_out, a_pc_plus4, a_inst_count;
    logic        a_tr_valid, a_fetch_err;
    logic [31:0] b_tr, b_pc_out, b_pc_plus4, b_inst_count;
    logic        b_tr_valid, b_fetch_err;

    exp_t sb[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   step_no = 0;

    instruction_fetch #(.MEM_DEPTH(64)) dut_a (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .br_taken(br_taken), .br_target(br_target),
        .TR(a_tr), .tr_valid(a_tr_valid), .pc_out(a_pc_out), .pc_plus4(a_pc_plus4),
        .fetch_err(a_fetch_err), .inst_count(a_inst_count)
    );

    instruction_fetch #(.MEM_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .br_taken(br_taken), .br_target(br_target),
        .TR(b_tr), .tr_valid(b_tr_valid), .pc_out(b_pc_out), .pc_plus4(b_pc_plus4),
        .fetch_err(b_fetch_err), .inst_count(b_inst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [31:0] tr, input logic v, input logic [31:0] pc,
                                input logic [31:0] cnt, input logic err);
        exp_t e;
        e.tr = tr;
        e.v = v;
        e.pc = pc;
        e.cnt = cnt;
        e.err = err;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s step %0d: observed %h expected %h", tag, step_no, obs, exp);
    endtask

    // Drive one cycle of controls, push the expectation, then compare after the edge.
    task automatic step(input logic r, input logic s, input logic f, input logic b,
                        input logic [31:0] tgt, input exp_t e);
        exp_t got;
        step_no++;
        rst = r;
        stall = s;
        flush = f;
        br_taken = b;
        br_target = tgt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("tr", a_tr, got.tr);
        check("tr_valid", {31'b0, a_tr_valid}, {31'b0, got.v});
        check("pc_out", a_pc_out, got.pc);
        check("pc_plus4", a_pc_plus4, got.pc + 32'd4);
        check("inst_count", a_inst_count, got.cnt);
        check("fetch_err", {31'b0, a_fetch_err}, {31'b0, got.err});
        $display("step %0d rst=%0b stall=%0b flush=%0b br=%0b tgt=%h | TR=%h v=%0b pc_out=%h cnt=%0d err=%0b",
                 step_no, r, s, f, b, tgt, a_tr, a_tr_valid, a_pc_out, a_inst_count, a_fetch_err);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0; br_target = 32'h0;

        // Reset state
        step(1, 0, 0, 0, 32'h0, mk(32'h0, 0, 32'h0, 0, 0));
        step(1, 0, 0, 0, 32'h0, mk(32'h0, 0, 32'h0, 0, 0));
        // Sequential fetch
        step(0, 0, 0, 0, 32'h0, mk(R0, 1, 32'h0, 1, 0));
        step(0, 0, 0, 0, 32'h0, mk(R1, 1, 32'h4, 2, 0));
        step(0, 0, 0, 0, 32'h0, mk(R2, 1, 32'h8, 3, 0));
        step(0, 0, 0, 0, 32'h0, mk(R3, 1, 32'hC, 4, 0));
        // Redirect back to word 1 (unaligned target 0x5)
        step(0, 0, 0, 1, 32'h5, mk(32'h0, 0, 32'hC, 4, 0));
        step(0, 0, 0, 0, 32'h0, mk(R1, 1, 32'h4, 5, 0));
        // Stall three cycles, flush asserted during the middle one
        step(0, 1, 0, 0, 32'h0, mk(R1, 1, 32'h4, 5, 0));
        step(0, 1, 1, 0, 32'h0, mk(R1, 1, 32'h4, 5, 0));
        step(0, 1, 0, 0, 32'h0, mk(R1, 1, 32'h4, 5, 0));
        step(0, 0, 0, 0, 32'h0, mk(R2, 1, 32'h8, 6, 0));
        // Redirect with stall, target 0x13 aligns to 0x10
        step(0, 1, 0, 1, 32'h13, mk(32'h0, 0, 32'h8, 6, 0));
        step(0, 0, 0, 0, 32'h0, mk(R4, 1, 32'h10, 7, 0));
        // Flush alone loses word 5
        step(0, 0, 1, 0, 32'h0, mk(32'h0, 0, 32'h10, 7, 0));
        step(0, 0, 0, 0, 32'h0, mk(R6, 1, 32'h18, 8, 0));
        // Redirect with flush to 0
        step(0, 0, 1, 1, 32'h0, mk(32'h0, 0, 32'h18, 8, 0));
        step(0, 0, 0, 0, 32'h0, mk(R0, 1, 32'h0, 9, 0));
        step(0, 0, 0, 0, 32'h0, mk(R1, 1, 32'h4, 10, 0));
        step(0, 0, 0, 0, 32'h0, mk(R2, 1, 32'h8, 11, 0));
        // Reset while PC=12 and stalled, then restart from word 0
        step(1, 1, 0, 0, 32'h0, mk(32'h0, 0, 32'h0, 0, 0));
        step(0, 0, 0, 0, 32'h0, mk(R0, 1, 32'h0, 1, 0));
        // PC wrap: top word is out of range, then PC wraps to 0
        step(0, 0, 0, 1, 32'hFFFF_FFFF, mk(32'h0, 0, 32'h0, 1, 0));
        step(0, 0, 0, 0, 32'h0, mk(32'h0, 1, 32'hFFFF_FFFC, 2, 1));
        step(0, 0, 0, 0, 32'h0, mk(R0, 1, 32'h0, 3, 1));
        step(0, 1, 0, 0, 32'h0, mk(R0, 1, 32'h0, 3, 1));
        step(1, 0, 0, 0, 32'h0, mk(32'h0, 0, 32'h0, 0, 0));

        // Out-of-range on the 4-word instance
        step(0, 0, 0, 0, 32'h0, mk(R0, 1, 32'h0, 1, 0));
        step(0, 0, 0, 0, 32'h0, mk(R1, 1, 32'h4, 2, 0));
        step(0, 0, 0, 0, 32'h0, mk(R2, 1, 32'h8, 3, 0));
        step(0, 0, 0, 0, 32'h0, mk(R3, 1, 32'hC, 4, 0));
        check("b_tr_last_word", b_tr, R3);
        check("b_fetch_err_before", {31'b0, b_fetch_err}, 32'h0);
        step(0, 0, 0, 0, 32'h0, mk(R4, 1, 32'h10, 5, 0));
        check("b_tr_oor", b_tr, 32'h0);
        check("b_tr_valid_oor", {31'b0, b_tr_valid}, 32'h1);
        check("b_pc_out_oor", b_pc_out, 32'h10);
        check("b_fetch_err_oor", {31'b0, b_fetch_err}, 32'h1);
        step(0, 0, 0, 0, 32'h0, mk(R5, 1, 32'h14, 6, 0));
        check("b_tr_oor2", b_tr, 32'h0);
        check("b_fetch_err_sticky", {31'b0, b_fetch_err}, 32'h1);
        check("b_inst_count_oor", b_inst_count, 32'd6);
        step(1, 0, 0, 0, 32'h0, mk(32'h0, 0, 32'h0, 0, 0));
        check("b_fetch_err_reset", {31'b0, b_fetch_err}, 32'h0);
        check("b_tr_valid_reset", {31'b0, b_tr_valid}, 32'h0);
        step(0, 0, 0, 0, 32'h0, mk(R0, 1, 32'h0, 1, 0));
        check("b_tr_restart", b_tr, R0);

        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
